// File: rtl/tick_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tick_sequencer_pkg                                             |
// | Purpose  : Shared constants and types for the tick sequencer: default     |
// |            datapath widths and the controller state encoding.             |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package tick_sequencer_pkg;

  // Default width of the period counter / period input.
  localparam int DEF_WIDTH     = 8;
  // Default width of the repeat counter / repeat input.
  localparam int DEF_REP_WIDTH = 4;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tick_sequencer_if                                              |
// | Purpose  : Control/status bundle between a front end and the tick         |
// |            sequencer.                                                      |
// | Signals  : start_i, stop_i, period_i, reps_i  - requests from front end    |
// |            busy_o, tick_o, done_o, cnt_o, rep_o - status from sequencer    |
// | Modports : master (front end), slave (sequencer)                            |
// | Revision : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface tick_sequencer_if
  import tick_sequencer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int REP_WIDTH = DEF_REP_WIDTH
) ();

  logic                 start_i;
  logic                 stop_i;
  logic [WIDTH-1:0]     period_i;
  logic [REP_WIDTH-1:0] reps_i;
  logic                 busy_o;
  logic                 tick_o;
  logic                 done_o;
  logic [WIDTH-1:0]     cnt_o;
  logic [REP_WIDTH-1:0] rep_o;

  modport master (
    output start_i, stop_i, period_i, reps_i,
    input  busy_o, tick_o, done_o, cnt_o, rep_o
  );

  modport slave (
    input  start_i, stop_i, period_i, reps_i,
    output busy_o, tick_o, done_o, cnt_o, rep_o
  );

endinterface
`default_nettype wire

// File: rtl/tick_sequencer_mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mod_counter                                                    |
// | Purpose  : Up counter with synchronous clear and enable and a runtime     |
// |            modulus. Flags the terminal count (modulus-1) while enabled.   |
// | Ports    : clk, rst      - clock, synchronous active-high reset            |
// |            clr, en       - synchronous clear (priority), count enable      |
// |            modulus       - count modulus M                                 |
// |            count         - current value                                   |
// |            wrap          - high while enabled and count == M-1             |
// | Params   : WIDTH - counter width                                           |
// |            WRAP  - 1: return to 0 after M-1; 0: keep counting (to M)       |
// | Revision : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module mod_counter #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] last_val;
  logic             at_last;

  assign last_val = modulus - WIDTH'(1);
  assign at_last  = (count == last_val);
  assign wrap     = en && at_last;

  // With WRAP=0 the counter steps past M-1 to M so the owner can read back
  // the completed count; the owner stops enabling it at that point.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (WRAP && at_last) begin
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tick_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tick_sequencer                                                 |
// | Purpose  : On an accepted start, latches period P and repeat count R and  |
// |            emits R one-cycle ticks spaced P cycles apart, then a one-cycle |
// |            done strobe. stop_i aborts a running train without done.        |
// | Ports    : clk_i - clock (rising edge)                                     |
// |            rst_i - synchronous active-high reset                           |
// |            bus   - tick_sequencer_if.slave (start/stop/period/reps in,     |
// |                    busy/tick/done/cnt/rep out)                             |
// | Revision : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tick_sequencer
  import tick_sequencer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int REP_WIDTH = DEF_REP_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  tick_sequencer_if.slave   bus
);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     period_q;
  logic [REP_WIDTH-1:0] reps_q;

  logic                 accept;
  logic                 abort;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 period_wrap;
  logic                 rep_last;
  logic [WIDTH-1:0]     cnt;
  logic [REP_WIDTH-1:0] rep;

  assign accept  = (state == IDLE) && bus.start_i;
  assign abort   = (state == RUN) && bus.stop_i;
  assign cnt_clr = accept || abort;
  assign cnt_en  = (state == RUN);

  // Latched train parameters; later changes on period_i/reps_i are ignored
  // until the next accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_q <= '0;
      reps_q   <= '0;
    end else if (accept) begin
      period_q <= bus.period_i;
      reps_q   <= bus.reps_i;
    end
  end

  // Period counter: cycles 0..P-1 while running; its wrap strobe is the tick.
  mod_counter #(
    .WIDTH (WIDTH),
    .WRAP  (1'b1)
  ) u_period (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .modulus (period_q),
    .count   (cnt),
    .wrap    (period_wrap)
  );

  // Repeat counter: advances once per tick and does not wrap, so rep reads R
  // after the final tick. Its terminal flag marks the last tick of the train.
  mod_counter #(
    .WIDTH (REP_WIDTH),
    .WRAP  (1'b0)
  ) u_reps (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (cnt_clr),
    .en      (period_wrap),
    .modulus (reps_q),
    .count   (rep),
    .wrap    (rep_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs depend only on registered state, counters and latched P/R.
  always_comb begin
    state_next = state;
    bus.busy_o = 1'b0;
    bus.tick_o = 1'b0;
    bus.done_o = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          // A zero period or zero repeat count completes immediately.
          if ((bus.period_i == '0) || (bus.reps_i == '0)) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        bus.busy_o = 1'b1;
        bus.tick_o = period_wrap;
        // Stop takes precedence over completion on a coinciding last tick.
        if (bus.stop_i) begin
          state_next = IDLE;
        end else if (rep_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.busy_o = 1'b1;
        bus.done_o = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.cnt_o = cnt;
  assign bus.rep_o = rep;

endmodule
`default_nettype wire

// File: tb/tb_tick_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tick_sequencer                                              |
// | Purpose  : Scoreboard bench for tick_sequencer. Each train pushes its     |
// |            per-cycle expected outputs; a negedge monitor pops and checks.  |
// | Revision : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_tick_sequencer;

  typedef struct {
    int    cyc;
    int    k;
    bit    busy;
    bit    tick;
    bit    done;
    bit    chk_cr;
    int    cnt;
    int    rep;
    string tag;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  exp_t mon_e;

  tick_sequencer_if #(.WIDTH(8), .REP_WIDTH(4)) bus ();

  tick_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard entry for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      chk($sformatf("%s k%0d missed", mon_e.tag, mon_e.k), cyc, mon_e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      chk($sformatf("%s k%0d busy", mon_e.tag, mon_e.k), int'(bus.busy_o), int'(mon_e.busy));
      chk($sformatf("%s k%0d tick", mon_e.tag, mon_e.k), int'(bus.tick_o), int'(mon_e.tick));
      chk($sformatf("%s k%0d done", mon_e.tag, mon_e.k), int'(bus.done_o), int'(mon_e.done));
      if (mon_e.chk_cr) begin
        chk($sformatf("%s k%0d cnt", mon_e.tag, mon_e.k), int'(bus.cnt_o), mon_e.cnt);
        chk($sformatf("%s k%0d rep", mon_e.tag, mon_e.k), int'(bus.rep_o), mon_e.rep);
      end
    end
  end

  // Advance to the cycle whose index (posedge count) is target, settled.
  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  // Reference model of one train, cycle k counted from the start edge.
  // halt >= 0: the train is cut off (stop or reset) before cycle halt.
  task automatic push_train(input int base, input int p, input int r,
                            input int halt, input int last, input string tag);
    bit   zero;
    int   t;
    exp_t e;
    zero = (p == 0) || (r == 0);
    t    = zero ? 0 : p * r;
    for (int k = 0; k <= last; k++) begin
      e.cyc = base + k; e.k = k; e.tag = tag;
      e.busy = 0; e.tick = 0; e.done = 0; e.chk_cr = 1; e.cnt = 0; e.rep = 0;
      if (halt >= 0 && k >= halt) begin
        // aborted / reset: idle with cleared counters
      end else if (k < t) begin
        e.busy = 1;
        e.cnt  = k % p;
        e.rep  = k / p;
        e.tick = ((k % p) == p - 1);
      end else if (k == t) begin
        e.busy = 1;
        e.done = 1;
        e.rep  = zero ? 0 : r;
      end else begin
        e.chk_cr = zero;
      end
      sb.push_back(e);
    end
  endtask

  // mode: 0 normal, 1 stop at cycle ev, 2 reset at cycle ev,
  //       3 re-start and change period/reps while busy.
  task automatic run_train(input int p, input int r, input int mode,
                           input int ev, input string tag);
    int base;
    int halt;
    int last;
    int t;
    int guard;
    t    = (p == 0 || r == 0) ? 0 : p * r;
    halt = (mode == 1 || mode == 2) ? ev + 1 : -1;
    last = (halt >= 0 ? halt : t + 1) + 2;
    @(posedge clk);
    #1;
    base         = cyc + 1;
    bus.start_i  = 1'b1;
    bus.period_i = 8'(p);
    bus.reps_i   = 4'(r);
    push_train(base, p, r, halt, last, tag);
    for (int k = 0; k <= last; k++) begin
      wait_cyc(base + k);
      if (k == 0) begin
        if (mode == 3) begin
          bus.period_i = 8'd9;
          bus.reps_i   = 4'd7;
        end else begin
          bus.start_i = 1'b0;
        end
      end
      if (mode == 3 && k == t + 1) bus.start_i = 1'b0;
      if (mode == 1 && k == ev)     bus.stop_i  = 1'b1;
      if (mode == 1 && k == ev + 1) bus.stop_i  = 1'b0;
      if (mode == 2 && k == ev)     rst = 1'b1;
      if (mode == 2 && k == ev + 1) rst = 1'b0;
    end
    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    chk({tag, " drain"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    exp_t e;
    n_vec        = 0;
    n_err        = 0;
    cyc          = 0;
    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.stop_i   = 1'b0;
    bus.period_i = 8'd0;
    bus.reps_i   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    e.cyc = cyc; e.k = 0; e.tag = "reset";
    e.busy = 0; e.tick = 0; e.done = 0; e.chk_cr = 1; e.cnt = 0; e.rep = 0;
    sb.push_back(e);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_train(5, 3, 2, 7, "rst_mid");
    run_train(2, 3, 0, 0, "after_rst");
    run_train(4, 3, 0, 0, "p4r3");
    run_train(1, 4, 0, 0, "p1r4");
    run_train(0, 5, 0, 0, "p0r5");
    run_train(6, 0, 0, 0, "p6r0");
    run_train(3, 5, 1, 5, "stop2nd");
    run_train(2, 2, 3, 0, "ignore");
    run_train(3, 2, 1, 5, "stop_last");
    run_train(3, 2, 1, 1, "stop_mid");
    run_train(255, 15, 0, 0, "max");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
